// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
package mem_arb_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned MEM_LAT     = 4;

    localparam logic FILL_DST_I = 1'b0;
    localparam logic FILL_DST_D = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StFillI,
        StFillD
    } arb_state_e;

endpackage

// File: rtl/blk_word_ctr.sv
// Saturating 3-bit word-within-block counter with synchronous clear.
module blk_word_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [2:0] count_o,
    output logic       tc_o
);

    logic [2:0] count_q, count_d;

    assign tc_o    = (count_q == 3'd7);
    assign count_o = count_q;

    // Holds at 7 so a stray increment cannot wrap back to word 0.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 3'd0;
        end else if (inc_i && !tc_o) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (D over I) arbiter between two cache controllers and a
// single pipelined memory port: single-word D writes and 8-word block fills.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WORDS = mem_arb_pkg::BLOCK_WORDS,
    parameter int unsigned MEM_LAT     = mem_arb_pkg::MEM_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  fill_valid,
    output logic                  fill_dst,
    output logic [2:0]            fill_word,
    output logic [15:0]           fill_data,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out,
    input  logic                  mem_data_valid
);

    import mem_arb_pkg::*;

    if (BLOCK_WORDS != 8 || MEM_LAT == 0 || ADDR_WIDTH < 5) begin : g_param_check
        $error("mem_arbiter: unsupported parameter combination");
    end

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  issued_all_q, issued_all_d;

    logic       in_fill;
    logic       ctr_clr;
    logic       issue_en;
    logic       rx_en;
    logic [2:0] issue_cnt;
    logic       issue_tc;
    logic [2:0] rx_cnt;
    logic       rx_tc;

    assign in_fill  = (state_q == StFillI) || (state_q == StFillD);
    assign ctr_clr  = !in_fill;
    assign issue_en = in_fill && !issued_all_q;
    assign rx_en    = in_fill && mem_data_valid;

    blk_word_ctr u_issue_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ctr_clr),
        .inc_i   (issue_en),
        .count_o (issue_cnt),
        .tc_o    (issue_tc)
    );

    blk_word_ctr u_rx_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ctr_clr),
        .inc_i   (rx_en),
        .count_o (rx_cnt),
        .tc_o    (rx_tc)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issued_all_d = issued_all_q;
        fill_valid   = 1'b0;
        fill_dst     = FILL_DST_I;
        fill_word    = 3'd0;
        fill_data    = 16'd0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = 16'd0;

        unique case (state_q)
            StIdle: begin
                issued_all_d = 1'b0;
                if (d_req) begin
                    state_d = d_wr ? StWrite : StFillD;
                    addr_d  = d_addr;
                end else if (i_req) begin
                    state_d = StFillI;
                    addr_d  = i_addr;
                end
            end
            StWrite: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = {addr_q[ADDR_WIDTH-1:1], 1'b0};
                mem_data_in = d_wdata;
                d_done      = 1'b1;
                state_d     = StIdle;
            end
            StFillI, StFillD: begin
                fill_dst = (state_q == StFillD) ? FILL_DST_D : FILL_DST_I;
                if (issue_en) begin
                    mem_enable = 1'b1;
                    mem_addr   = {addr_q[ADDR_WIDTH-1:4], issue_cnt, 1'b0};
                    if (issue_tc) begin
                        issued_all_d = 1'b1;
                    end
                end
                if (mem_data_valid) begin
                    fill_valid = 1'b1;
                    fill_word  = rx_cnt;
                    fill_data  = mem_data_out;
                    // Word 7 arriving closes the fill in the same cycle.
                    if (rx_tc) begin
                        i_done  = (state_q == StFillI);
                        d_done  = (state_q == StFillD);
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            issued_all_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issued_all_q <= issued_all_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a grant-timeline reference model.
module tb_mem_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned LAT = 4;

    typedef enum int {OpNone, OpWr, OpFillI, OpFillD} op_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [15:0]   d_wdata;
    logic          fill_valid, fill_dst, i_done, d_done, busy;
    logic [2:0]    fill_word;
    logic [15:0]   fill_data;
    logic          mem_enable, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data_in, mem_data_out;
    logic          mem_data_valid;

    logic          spur;
    logic [15:0]   junk;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .BLOCK_WORDS (8),
        .MEM_LAT     (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .d_req          (d_req),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .fill_valid     (fill_valid),
        .fill_dst       (fill_dst),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .i_done         (i_done),
        .d_done         (d_done),
        .busy           (busy),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid)
    );

    function automatic logic [15:0] init_word(input logic [14:0] a);
        return {a[7:0], a[14:7]} ^ 16'h5A3C;
    endfunction

    // Memory: word-addressed store plus a LAT-deep read pipeline, not reset.
    bit [15:0] env_mem [32768];
    bit        env_wr  [32768];
    bit        pv [LAT];
    bit [15:0] pd [LAT];

    always @(posedge clk) begin
        if (mem_enable && mem_wr) begin
            env_mem[mem_addr[15:1]] <= mem_data_in;
            env_wr[mem_addr[15:1]]  <= 1'b1;
        end
        pv[0] <= mem_enable && !mem_wr;
        pd[0] <= env_wr[mem_addr[15:1]] ? env_mem[mem_addr[15:1]] : init_word(mem_addr[15:1]);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mem_data_valid = pv[LAT-1] | spur;
    assign mem_data_out   = pv[LAT-1] ? pd[LAT-1] : junk;

    // Reference: the op in flight and the cycle it was granted in.
    op_e       m_op = OpNone;
    int        cyc  = 0;
    int        m_t0 = 0;
    logic [15:0] m_addr, m_wdat;
    bit [15:0] ref_mem [32768];
    bit        ref_wr  [32768];

    function automatic int op_len(input op_e op);
        return (op == OpWr) ? 1 : 12;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op <= OpNone;
        end else begin
            cyc <= cyc + 1;
            if (m_op != OpNone) begin
                if (cyc - m_t0 == op_len(m_op)) m_op <= OpNone;
            end else if (d_req) begin
                m_op   <= d_wr ? OpWr : OpFillD;
                m_t0   <= cyc;
                m_addr <= d_addr;
                m_wdat <= d_wdata;
                if (d_wr) begin
                    ref_mem[d_addr[15:1]] <= d_wdata;
                    ref_wr[d_addr[15:1]]  <= 1'b1;
                end
            end else if (i_req) begin
                m_op   <= OpFillI;
                m_t0   <= cyc;
                m_addr <= i_addr;
            end
        end
    end

    bit i_owe, d_owe, prev_idone, prev_ddone, rand_en;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s @cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        int          c;
        int          k;
        logic [14:0] widx;
        logic        e_busy, e_en, e_wr, e_fv, e_dst, e_idone, e_ddone;
        logic [15:0] e_addr, e_din, e_fd;
        logic [2:0]  e_word;
        c       = cyc - m_t0;
        e_busy  = (m_op != OpNone);
        e_en    = 0; e_wr = 0; e_fv = 0; e_dst = 0; e_idone = 0; e_ddone = 0;
        e_addr  = 0; e_din = 0; e_fd = 0; e_word = 0;
        if (m_op == OpWr) begin
            e_en    = 1;
            e_wr    = 1;
            e_addr  = m_addr & 16'hFFFE;
            e_din   = m_wdat;
            e_ddone = 1;
        end else if (m_op == OpFillI || m_op == OpFillD) begin
            e_dst = (m_op == OpFillD);
            if (c >= 1 && c <= 8) begin
                e_en   = 1;
                e_addr = (m_addr & 16'hFFF0) + 16'(2 * (c - 1));
            end
            if (c >= 5 && c <= 12) begin
                k      = c - 5;
                widx   = 15'((m_addr & 16'hFFF0) >> 1) + 15'(k);
                e_fv   = 1;
                e_word = 3'(k);
                e_fd   = ref_wr[widx] ? ref_mem[widx] : init_word(widx);
            end
            if (c == 12) begin
                e_idone = (m_op == OpFillI);
                e_ddone = (m_op == OpFillD);
            end
        end
        check_eq("busy",        32'(busy),        32'(e_busy));
        check_eq("mem_enable",  32'(mem_enable),  32'(e_en));
        check_eq("mem_wr",      32'(mem_wr),      32'(e_wr));
        check_eq("mem_addr",    32'(mem_addr),    32'(e_addr));
        check_eq("mem_data_in", 32'(mem_data_in), 32'(e_din));
        check_eq("fill_valid",  32'(fill_valid),  32'(e_fv));
        check_eq("fill_dst",    32'(fill_dst),    32'(e_dst));
        check_eq("fill_word",   32'(fill_word),   32'(e_word));
        check_eq("fill_data",   32'(fill_data),   32'(e_fd));
        check_eq("i_done",      32'(i_done),      32'(e_idone));
        check_eq("d_done",      32'(d_done),      32'(e_ddone));
        prev_idone = e_idone;
        prev_ddone = e_ddone;
    endtask

    // Requesters hold req until their done pulse, except for deliberate drops.
    task automatic drive();
        int c;
        c = cyc - m_t0;
        if (prev_idone) begin i_req = 0; i_owe = 0; end
        if (prev_ddone) begin d_req = 0; d_owe = 0; end
        if (rand_en) begin
            if (i_req && m_op == OpFillI && c >= 2 && c <= 10 && $urandom_range(15) == 0) i_req = 0;
            if (d_req && m_op == OpFillD && c >= 2 && c <= 10 && $urandom_range(15) == 0) d_req = 0;
            if (!i_owe && $urandom_range(5) == 0) begin
                i_req = 1; i_owe = 1; i_addr = 16'($urandom);
            end
            if (!d_owe && $urandom_range(5) == 0) begin
                d_req   = 1; d_owe = 1;
                d_wr    = ($urandom_range(2) == 0);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            if ($urandom_range(3) == 0) i_addr = 16'($urandom);
            if (!(d_req && d_wr) && $urandom_range(3) == 0) d_addr = 16'($urandom);
        end
        spur = (m_op == OpNone || m_op == OpWr) && ($urandom_range(2) == 0);
        junk = 16'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && (m_op != OpNone || i_owe || d_owe); n++) step();
        check_eq("drain", 32'({i_owe, d_owe, m_op != OpNone}), 32'd0);
    endtask

    initial begin
        rst_n = 0; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        spur = 0; junk = 16'h1234;
        i_owe = 0; d_owe = 0; prev_idone = 0; prev_ddone = 0; rand_en = 0;
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        rst_n = 1;

        // I fill of 0x1236: reads 0x1230..0x123E, data words 0..7, i_done at cycle 12.
        i_addr = 16'h1236; i_req = 1; i_owe = 1;
        repeat (14) step();
        wait_idle();

        // Simultaneous requests: D fill of 0x0040 first, then the held I fill.
        d_addr = 16'h0040; d_wr = 0; d_req = 1; d_owe = 1;
        i_addr = 16'h0800; i_req = 1; i_owe = 1;
        repeat (28) step();
        wait_idle();

        // Write 0xBEEF to 0x0103, then fill block 0x0100 to read it back at word 1.
        d_addr = 16'h0103; d_wdata = 16'hBEEF; d_wr = 1; d_req = 1; d_owe = 1;
        repeat (3) step();
        d_addr = 16'h0100; d_wr = 0; d_req = 1; d_owe = 1;
        repeat (14) step();
        wait_idle();

        // Reset in cycle 6 of an I fill: no done, in-flight data ignored.
        i_addr = 16'h2468; i_req = 1; i_owe = 1;
        repeat (5) step();
        @(posedge clk);
        #2;
        rst_n = 0; i_req = 0; i_owe = 0;
        #1;
        check_all();
        repeat (2) step();
        rst_n = 1;
        repeat (12) step();

        // i_req dropped in cycle 3: fill still completes.
        i_addr = 16'h7A5C; i_req = 1; i_owe = 1;
        repeat (2) step();
        @(posedge clk);
        #1;
        i_req = 0;
        @(negedge clk);
        check_all();
        repeat (11) step();
        wait_idle();

        rand_en = 1;
        repeat (2500) step();
        rand_en = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
